// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-split helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_INSTALL
  } state_e;

  localparam int DEF_INDEX_BITS  = 5;
  localparam int DEF_OFFSET_BITS = 4;
  localparam int LINE_BYTES      = 1 << DEF_OFFSET_BITS;
  localparam int TAG_BITS        = 32 - DEF_INDEX_BITS - DEF_OFFSET_BITS;

  // Helpers return right-justified 32-bit fields; callers size-cast to the field width.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int ib, input int ob);
    return pc >> (ib + ob);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int ib, input int ob);
    return (pc >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_word(input logic [31:0] pc, input int ob);
    return (pc & ((32'd1 << ob) - 32'd1)) >> 2;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] pc, input int ob);
    return pc & ~((32'd1 << ob) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read of one line, synchronous write of one line.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    we,
  input  logic [INDEX_BITS-1:0]                   wr_index,
  input  logic [31-INDEX_BITS-OFFSET_BITS:0]      wr_tag,
  input  logic [(8<<OFFSET_BITS)-1:0]             wr_data,
  input  logic [INDEX_BITS-1:0]                   rd_index,
  output logic                                    rd_valid,
  output logic [31-INDEX_BITS-OFFSET_BITS:0]      rd_tag,
  output logic [(8<<OFFSET_BITS)-1:0]             rd_data
);

  localparam int NLINES    = 1 << INDEX_BITS;
  localparam int TAG_W     = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_BITS = 8 << OFFSET_BITS;

  logic [NLINES-1:0]    valid_q;
  logic [NLINES-1:0]    valid_d;
  logic [TAG_W-1:0]     tag_mem  [NLINES];
  logic [LINE_BITS-1:0] data_mem [NLINES];

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  // Tag/data carry no reset so they map onto plain storage; valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with byte-serial line refill.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_ready_in,
  input  logic [31:0] fetch_pc,
  input  logic        clear,
  output logic        instcache_ready_out,
  output logic [31:0] inst_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din
);

  localparam int LB        = 1 << OFFSET_BITS;
  localparam int LINE_BITS = 8 * LB;
  localparam int TAG_W     = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int CNT_W     = OFFSET_BITS + 1;
  localparam logic [CNT_W-1:0] LB_CNT = CNT_W'(LB);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]     cap_cnt_q, cap_cnt_d;
  logic                 issued_q, issued_d;
  logic [31:0]          base_q, base_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;
  logic                 ready_q, ready_d;
  logic [31:0]          inst_q, inst_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;

  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_data;
  logic [LINE_BITS-1:0]  line_shift;
  logic [31:0]           word_sel;
  logic                  hit;
  logic                  array_we;

  assign rd_index   = INDEX_BITS'(pc_index(fetch_pc, INDEX_BITS, OFFSET_BITS));
  assign lookup_tag = TAG_W'(pc_tag(fetch_pc, INDEX_BITS, OFFSET_BITS));
  assign word_sel   = pc_word(fetch_pc, OFFSET_BITS);
  assign line_shift = rd_data >> (word_sel * 32);
  assign hit        = rd_valid && (rd_tag == lookup_tag);
  assign array_we   = rdy && (state_q == ST_INSTALL);

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .we      (array_we),
    .wr_index(INDEX_BITS'(pc_index(base_q, INDEX_BITS, OFFSET_BITS))),
    .wr_tag  (TAG_W'(pc_tag(base_q, INDEX_BITS, OFFSET_BITS))),
    .wr_data (buf_q),
    .rd_index(rd_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    issued_d    = issued_q;
    base_d      = base_q;
    buf_d       = buf_q;
    ready_d     = 1'b0;
    inst_d      = inst_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        // While the response strobe is up the old request is still held, so skip it.
        if (fetch_ready_in && !clear && !ready_q) begin
          if (hit) begin
            ready_d = 1'b1;
            inst_d  = line_shift[31:0];
          end else begin
            base_d      = line_base(fetch_pc, OFFSET_BITS);
            issue_cnt_d = '0;
            cap_cnt_d   = '0;
            issued_d    = 1'b0;
            mem_req_d   = 1'b1;
            mem_addr_d  = line_base(fetch_pc, OFFSET_BITS);
            state_d     = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        issued_d = mem_grant && (issue_cnt_q < LB_CNT);
        if (issued_d) issue_cnt_d = issue_cnt_q + 1'b1;
        // mem_din answers the address issued one cycle earlier.
        if (issued_q) begin
          buf_d[{cap_cnt_q[OFFSET_BITS-1:0], 3'b000} +: 8] = mem_din;
          cap_cnt_d = cap_cnt_q + 1'b1;
          if (cap_cnt_d == LB_CNT) begin
            state_d   = ST_INSTALL;
            mem_req_d = 1'b0;
          end
        end
        mem_addr_d = base_q + {{(32-CNT_W){1'b0}}, issue_cnt_d};
      end
      ST_INSTALL: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      issued_q    <= 1'b0;
      base_q      <= '0;
      buf_q       <= '0;
      ready_q     <= 1'b0;
      inst_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      issued_q    <= issued_d;
      base_q      <= base_d;
      buf_q       <= buf_d;
      ready_q     <= ready_d;
      inst_q      <= inst_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // A clear in the response cycle still has to cancel that response.
  assign instcache_ready_out = ready_q && !clear;
  assign inst_out            = inst_q;
  assign mem_req             = mem_req_q;
  assign mem_addr            = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fills, hits, eviction, grant delay, clear, reset and rdy stalls.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_ready_in;
  logic [31:0] fetch_pc;
  logic        clear;
  logic        instcache_ready_out;
  logic [31:0] inst_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_din;

  int n_vec = 0;
  int n_bad = 0;
  int grant_delay = 0;
  int wait_cnt = 0;

  icache dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .fetch_ready_in     (fetch_ready_in),
    .fetch_pc           (fetch_pc),
    .clear              (clear),
    .instcache_ready_out(instcache_ready_out),
    .inst_out           (inst_out),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_grant          (mem_grant),
    .mem_din            (mem_din)
  );

  always #5 clk = ~clk;

  // Memory: byte = addr[7:0] ^ {addr[11:8],4'h0}, one cycle read latency, frozen by rdy.
  always @(posedge clk) begin
    if (rdy) mem_din <= mem_addr[7:0] ^ {mem_addr[11:8], 4'h0};
  end

  // Arbiter: grant after grant_delay cycles of mem_req, held while mem_req stays high.
  always @(posedge clk) begin
    if (!rst)     wait_cnt <= 0;
    else if (rdy) wait_cnt <= mem_req ? wait_cnt + 1 : 0;
  end
  assign mem_grant = mem_req && (wait_cnt >= grant_delay);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic wait_resp(input logic [31:0] base, input int bound, output int lat,
                           output logic [31:0] data, output int reqc, output bit walk_ok);
    int g;
    g = 0;
    lat = -1;
    data = '0;
    reqc = 0;
    walk_ok = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (mem_req) begin
        if (mem_addr !== base + g) walk_ok = 1'b0;
        reqc++;
        if (mem_grant && g < 16) g++;
      end
      if (instcache_ready_out) begin
        lat = i;
        data = inst_out;
        break;
      end
    end
  endtask

  task automatic do_req(input string tag, input logic [31:0] pc, input int exp_lat,
                        input logic [31:0] exp_data, input int exp_reqc);
    int lat;
    logic [31:0] data;
    int reqc;
    bit walk_ok;
    fetch_pc = pc;
    fetch_ready_in = 1'b1;
    wait_resp(pc & 32'hFFFF_FFF0, 60, lat, data, reqc, walk_ok);
    fetch_ready_in = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, data, exp_data);
    check({tag, " req cycles"}, reqc, exp_reqc);
    if (exp_reqc > 0) check({tag, " addr walk"}, {31'd0, walk_ok}, 32'd1);
    step();
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    rdy = 1'b1;
    fetch_ready_in = 1'b0;
    fetch_pc = '0;
    clear = 1'b0;
    repeat (3) step();
    check("reset ready", {31'd0, instcache_ready_out}, 32'd0);
    check("reset inst", inst_out, 32'd0);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    step();

    do_req("cold miss 0x10", 32'h10, 20, 32'h1312_1110, 17);
    do_req("hit 0x14", 32'h14, 1, 32'h1716_1514, 0);
    do_req("b2b hit 0x18", 32'h18, 1, 32'h1B1A_1918, 0);

    do_req("fill 0x0", 32'h0, 20, 32'h0302_0100, 17);
    do_req("evict 0x200", 32'h200, 20, 32'h2322_2120, 17);
    do_req("refill 0x0", 32'h0, 20, 32'h0302_0100, 17);

    grant_delay = 5;
    do_req("grant delay 0x24", 32'h24, 25, 32'h2726_2524, 22);
    grant_delay = 0;

    // Clear while the refill of line 0x30 is in progress.
    fetch_pc = 32'h30;
    fetch_ready_in = 1'b1;
    repeat (7) step();
    clear = 1'b1;
    fetch_ready_in = 1'b0;
    step();
    clear = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (instcache_ready_out) pulses++;
    end
    check("clear no response", pulses, 0);
    do_req("post-clear hit 0x30", 32'h30, 1, 32'h3332_3130, 0);

    // rdy low for three cycles starting with the edge that samples a hit request.
    fetch_pc = 32'h14;
    fetch_ready_in = 1'b1;
    rdy = 1'b0;
    pulses = 0;
    repeat (3) begin
      step();
      if (instcache_ready_out) pulses++;
    end
    rdy = 1'b1;
    check("rdy stall no early resp", pulses, 0);
    do_req("rdy stall hit 0x14", 32'h14, 1, 32'h1716_1514, 0);

    // Reset in the middle of a refill.
    fetch_pc = 32'h40;
    fetch_ready_in = 1'b1;
    repeat (5) step();
    check("mid-refill mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    fetch_ready_in = 1'b0;
    step();
    check("reset drops mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    step();
    do_req("after reset 0x40", 32'h40, 20, 32'h4342_4140, 17);
    do_req("after reset 0x10 miss", 32'h10, 20, 32'h1312_1110, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
